// File: rtl/dmem_responder_pkg.sv
// Shared types and codes for the M-stage data-port responder.
// Latency: none (declarations only).
// Backpressure: n/a.
package dmem_responder_pkg;

  // Responder FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dmem_state_e;

  // Store size codes (ST_Size)
  localparam logic [1:0] FNC_SB    = 2'b00;
  localparam logic [1:0] FNC_SH    = 2'b01;
  localparam logic [1:0] FNC_SW    = 2'b10;
  localparam logic [1:0] FNC_SNONE = 2'b11;

  // Load size codes (LD_Size, func3)
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  // True when the access cannot be served by a single aligned lane group.
  // Undefined load codes fetch a full word, so they are treated as words.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [1:0] addr_lo,
                                         input logic [1:0] st_size,
                                         input logic [2:0] ld_size);
    logic is_half;
    logic is_word;
    if (we) begin
      is_half = (st_size == FNC_SH);
      is_word = (st_size == FNC_SW);
    end else begin
      is_half = (ld_size == FNC_LH) || (ld_size == FNC_LHU);
      is_word = !((ld_size == FNC_LB) || (ld_size == FNC_LBU) || is_half);
    end
    return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_responder_align.sv
// Byte-lane steering: store mask/replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none, no state.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_size,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store path: the memory picks bytes by mask, so data is replicated to every lane
  always_comb begin
    st_wmask     = 4'b0000;
    st_wdata_rep = st_wdata;
    case (st_size)
      FNC_SB: begin
        st_wmask     = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      FNC_SH: begin
        st_wmask     = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      FNC_SW: begin
        st_wmask     = 4'b1111;
      end
      default: begin
        st_wmask     = 4'b0000;
      end
    endcase
  end

  // Load path: pick the addressed byte/half, then sign- or zero-extend
  always_comb begin
    ld_byte = ld_word[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_size)
      FNC_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      FNC_LBU: ld_data = {24'd0, ld_byte};
      FNC_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      FNC_LHU: ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-port responder: latches one access, runs the memory handshake, returns load data.
// Latency: store 3 cycles, load 4 cycles minimum (request cycle to the stall=0 cycle).
// Backpressure: stall held while busy; mem_req_valid held with stable payload until mem_req_ready.
// Optional: DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a misalign pulse with no memory traffic.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_st_size,
  input  logic [2:0]    req_ld_size,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data,
  output logic          misalign
);

  dmem_state_e state_q, state_d;

  logic        we_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  ld_size_q;
  logic        fault_now;
  logic        fault_q;
  logic        take_req;

  logic [3:0]  st_wmask;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;

  // Store lanes come from the live request; load lanes from the latched address/size
  dmem_lane_align u_align (
    .st_addr_lo   (req_addr[1:0]),
    .st_size      (req_st_size),
    .st_wdata     (req_wdata),
    .st_wmask     (st_wmask),
    .st_wdata_rep (st_wdata_rep),
    .ld_addr_lo   (addr_lo_q),
    .ld_size      (ld_size_q),
    .ld_word      (mem_resp_data),
    .ld_data      (ld_data)
  );

  assign take_req = (state_q == ST_IDLE) && req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_now = is_misaligned(req_we, req_addr[1:0], req_st_size, req_ld_size);

  // Remember whether the access in flight was trapped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (take_req) begin
      fault_q <= fault_now;
    end
  end

  assign misalign = (state_q == ST_DONE) && fault_q;
`else
  assign fault_now = 1'b0;
  assign fault_q   = 1'b0;
  assign misalign  = 1'b0;
`endif

  // State register; reset asserts immediately so mem_req_valid drops mid-transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus combinational stall/request strobes
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          state_d = fault_now ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = we_q ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Core advances this cycle; any req_valid here waits for IDLE
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rdata_valid = (state_q == ST_DONE) && !we_q && !fault_q;

  // Request capture in IDLE and load-data capture in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      addr_lo_q <= 2'b00;
      ld_size_q <= 3'b000;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (take_req) begin
        we_q      <= req_we;
        addr_lo_q <= req_addr[1:0];
        ld_size_q <= req_ld_size;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[AW-1:2], 2'b00};
        mem_wmask <= req_we ? st_wmask : 4'b0000;
        mem_wdata <= req_we ? st_wdata_rep : '0;
      end
      if ((state_q == ST_WAIT) && mem_resp_valid) begin
        rdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized accesses vs. a reference model.
// Latency: checks the full per-cycle stall profile of every access.
// Backpressure: memory model inserts random ready and response delays.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_st_size;
  logic [2:0]  req_ld_size;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        misalign;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rdata;

  dmem_responder #(.AW(32), .DW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_st_size    (req_st_size),
    .req_ld_size    (req_ld_size),
    .stall          (stall),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte-lane arithmetic on the address ----
  function automatic logic [3:0] m_mask(input logic [1:0] st, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    case (st)
      2'd0: return 4'(1 << lane);
      2'd1: return (lane >= 2) ? 4'b1100 : 4'b0011;
      2'd2: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] w);
    case (st)
      2'd0: return (w % 256) * 32'h0101_0101;
      2'd1: return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] ld, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> ((a % 4) * 8)) % 256;
    h = (word >> (((a % 4) >= 2) ? 16 : 0)) % 65536;
    case (ld)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return word;
    endcase
  endfunction

  function automatic bit m_fault(input logic we, input logic [1:0] st, input logic [2:0] ld,
                                 input logic [31:0] a);
    bit half;
    bit word;
    half = we ? (st == 2'd1) : (ld == 3'd1 || ld == 3'd5);
    word = we ? (st == 2'd2) : !(ld == 3'd0 || ld == 3'd4 || half);
    return TRAP && ((half && (a % 2 != 0)) || (word && (a % 4 != 0)));
  endfunction

  // One access as seen by the core and the memory; every cycle is checked.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] st, input logic [2:0] ld, input int rdly,
                        input int wdly, input logic [31:0] word, input bit hold_next);
    bit fault;
    fault = m_fault(we, st, ld, a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = w;
    req_st_size = st; req_ld_size = ld;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_mreq", mem_req_valid, 0);
    if (!fault) begin
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = $urandom;  // must be ignored outside WAIT
        #1;
        chk("issue_stall", stall, 1);
        chk("issue_mreq", mem_req_valid, 1);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      chk("acc_stall", stall, 1);
      chk("acc_mreq", mem_req_valid, 1);
      chk("acc_addr", mem_addr, {a[31:2], 2'b00});
      chk("acc_we", mem_we, we);
      chk("acc_mask", mem_wmask, we ? m_mask(st, a) : 4'b0000);
      if (we && st != 2'd3) chk("acc_wdata", mem_wdata, m_wdata(st, w));
      if (!we) begin
        for (int i = 0; i < wdly; i++) begin
          @(negedge clk);
          mem_req_ready = 1'b0;
          #1;
          chk("wait_stall", stall, 1);
          chk("wait_mreq", mem_req_valid, 0);
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = word;
        #1;
        chk("resp_stall", stall, 1);
        model_rdata = m_load(ld, a, word);
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    req_valid = hold_next;
    #1;
    chk("done_stall", stall, 0);
    chk("done_rvld", rdata_valid, (!we && !fault) ? 1 : 0);
    chk("done_rdata", rdata, model_rdata);
    chk("done_misalign", misalign, fault ? 1 : 0);
    chk("done_mreq", mem_req_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_st_size = 2'd0; req_ld_size = 3'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_rdata = '0;

    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_rvld", rdata_valid, 0);
    chk("rst_mreq", mem_req_valid, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mask", mem_wmask, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    access(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 3'd0, 1, 0, 32'h0, 1'b0);  // SB, ready after 2
    access(1'b0, 32'h0000_2002, 32'h0,         2'd3, 3'd0, 0, 0, 32'h12F4_5678, 1'b0);  // LB
    access(1'b0, 32'h0000_2002, 32'h0,         2'd3, 3'd4, 0, 0, 32'h12F4_5678, 1'b0);  // LBU
    access(1'b0, 32'h0000_2002, 32'h0,         2'd3, 3'd5, 0, 1, 32'h8001_ABCD, 1'b0);  // LHU
    access(1'b0, 32'h0000_2000, 32'h0,         2'd3, 3'd1, 0, 0, 32'h8001_ABCD, 1'b0);  // LH
    access(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'd2, 3'd0, 0, 0, 32'h0, 1'b1);  // SW, req held in DONE
    access(1'b0, 32'h0000_2004, 32'h0,         2'd3, 3'd2, 0, 0, 32'hCAFE_F00D, 1'b0);  // LW 1,1,1,0
    access(1'b1, 32'h0000_2006, 32'h1234_5678, 2'd1, 3'd0, 2, 0, 32'h0, 1'b0);  // SH upper
    access(1'b1, 32'h0000_2001, 32'h1234_5678, 2'd3, 3'd0, 0, 0, 32'h0, 1'b0);  // no-write
    access(1'b0, 32'h0000_2003, 32'h0,         2'd3, 3'd7, 0, 0, 32'h7654_3210, 1'b0);  // undefined code
    access(1'b1, 32'h0000_3002, 32'h5555_AAAA, 2'd2, 3'd0, 0, 0, 32'h0, 1'b0);  // SW misaligned

    // Reset asserted while waiting for the load response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000; req_ld_size = 3'd2;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstw_stall", stall, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_mreq", mem_req_valid, 0);
    chk("rstw_stall0", stall, 0);
    chk("rstw_rdata", rdata, 0);
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
    #1;
    chk("rstw_rvld", rdata_valid, 0);
    chk("rstw_stall1", stall, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("rstw_rvld2", rdata_valid, 0);
    chk("rstw_rdata2", rdata, 0);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      logic        r_we;
      logic [2:0]  r_ld;
      logic [1:0]  r_st;
      r_we = 1'($urandom_range(0, 1));
      r_st = 2'($urandom_range(0, 3));
      r_ld = 3'($urandom_range(0, 7));
      access(r_we, $urandom, $urandom, r_st, r_ld, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    req_valid = 1'b0; mem_resp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline controller's M-stage data port.
- Accepts one load or store per request, in the controller's encoding: write-enable, ST_Size (2-bit) and LD_Size (func3, 3-bit).
- Generates byte masks and store alignment, runs a valid/ready request plus response handshake to backing memory, and returns an aligned, extended load result.
- Stalls the pipeline until the access completes.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; fixed at 32, and the byte-lane logic depends on it.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents an access; held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, unaligned (lane 0).
- req_st_size  in  2  00=byte, 01=half, 10=word, 11=no-write.
- req_ld_size  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- stall  out  1  freeze the pipeline.
- rdata  out  DW  aligned and extended load data.
- rdata_valid  out  1  one-cycle pulse at load completion.
- mem_req_valid  out  1  backing-memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  AW  {req_addr[AW-1:2],2'b00}.
- mem_wmask  out  4  byte write enables.
- mem_wdata  out  DW  lane-replicated store data.
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  DW  read word.
- misalign  out  1  alignment fault pulse (optional feature).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - stall, rdata_valid, mem_req_valid, mem_we, misalign = 0.
  - rdata, mem_addr, mem_wmask, mem_wdata = 0.
- States:
  - IDLE: if req_valid, latch we/addr/wdata/sizes and go to ISSUE.
  - ISSUE: mem_req_valid=1 with registered addr/we/mask/data. On mem_req_ready, a store goes to DONE and a load goes to WAIT.
  - WAIT: on mem_resp_valid, register the extracted data into rdata and go to DONE.
  - DONE: one cycle, then IDLE.
- stall is combinational: 1 in ISSUE and WAIT, and 1 in IDLE when req_valid=1; otherwise 0.
  - In DONE stall=0 and the core advances.
  - A req_valid seen in DONE is ignored; the next request is taken in IDLE.
- Minimum latency:
  - Store: 3 cycles from first req_valid to the stall=0 cycle (IDLE, ISSUE+ready, DONE).
  - Load: 4 cycles.
- Handshake:
  - mem_req_valid stays high, with outputs stable, until mem_req_ready.
  - mem_resp_valid is never earlier than the cycle after acceptance, and is ignored outside WAIT.
- Store mask and data:
  - Byte: mask=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
  - Half: mask=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - Word: mask=4'b1111.
  - 11: mask=0; the handshake still completes.
- Load extraction:
  - LB/LBU: byte at lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU: half at addr[1]; LH sign-extends, LHU zero-extends.
  - LW and undefined codes (011, 110, 111): full word.
- rdata_valid=1 only in DONE for loads; rdata holds until the next load completes.
- Reset mid-transaction: mem_req_valid drops immediately and the FSM returns to IDLE. Stale responses are ignored because the FSM is not in WAIT.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Fault condition: half with addr[0]=1, or word with addr[1:0]!=0.
  - On a fault the FSM goes IDLE→DONE with no memory transaction. misalign=1 in DONE, rdata_valid=0, rdata unchanged.
- Undefined:
  - Low address bits beyond lane selection are ignored; a word access uses addr[31:2].
  - misalign is tied 0.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
  - ST_Size codes and LD_Size func3 codes, reusing the existing FNC_* load/store constants.
- Sub-module dmem_lane_align (combinational):
  - Store path: mask and replication.
  - Load path: extract and extend.
- The FSM and registers stay in dmem_responder.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, ready after 2 cycles → mem_wmask=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, stall released 4 cycles after request.
- LB addr=0x2002, resp 0x12F45678 → rdata=0xFFFFFFF4, rdata_valid one pulse. LBU at the same address → 0x000000F4.
- LHU addr=0x2002, resp 0x8001ABCD → rdata=0x00008001. LH addr=0x2000 → 0xFFFFABCD.
- LW with ready tied high and resp one cycle later → 4-cycle stall profile 1,1,1,0. Back-to-back SW then LW → second request accepted only after DONE.
- Reset asserted in WAIT, response arrives after release → FSM in IDLE, rdata_valid stays 0, mem_req_valid=0 during reset.
- With DMEM_MISALIGN_TRAP_EN, SW addr=0x3002 → no mem_req_valid, misalign pulse in cycle 2, stall=0 in cycle 2.
